ps2_scancode_decoder: RTL and testbench

PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

---
 rtl/ps2_pkg.sv | 58 +++++
 rtl/ps2_event_fifo.sv | 72 +++++++
 rtl/ps2_scancode_decoder.sv | 151 +++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ============================================================================
// Module      : ps2_pkg
// Description : Shared types and constants for the PS/2 scancode decoder:
//               prefix FSM state type, prefix byte values, key-event record
//               and the bit positions of the event and status bus words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

  // Prefix-tracking states of the scancode decoder
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GOT_E0   = 2'd1,
    ST_GOT_F0   = 2'd2,
    ST_GOT_E0F0 = 2'd3
  } ps2_state_t;

  // Prefix bytes: E0 marks an extended key, F0 marks a key release
  localparam logic [7:0] c_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] c_PREFIX_BRK = 8'hF0;

  // One buffered key event
  typedef struct packed {
    logic [7:0] code;
    logic       released;
    logic       extended;
  } ps2_event_t;

  // Event word layout
  localparam int c_EVT_CODE_LSB = 24;
  localparam int c_EVT_REL_BIT  = 23;
  localparam int c_EVT_EXT_BIT  = 22;

  // Status word layout
  localparam int c_STS_READY_BIT = 31;
  localparam int c_STS_OVF_BIT   = 30;
  localparam int c_STS_PAR_BIT   = 29;
  localparam int c_STS_CNT_LSB   = 24;
  localparam int c_STS_CNT_W     = 5;

  // Occupancy counter width: enough for a 32-entry buffer
  localparam int c_CNT_W = 6;

  // Format a key event into the bus event word
  function automatic logic [31:0] event_word(input ps2_event_t evt);
    logic [31:0] word;
    word = 32'h0;
    word[c_EVT_CODE_LSB +: 8] = evt.code;
    word[c_EVT_REL_BIT]       = evt.released;
    word[c_EVT_EXT_BIT]       = evt.extended;
    return word;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_event_fifo.sv
// ============================================================================
// Module      : ps2_event_fifo
// Description : Key-event buffer with zero-latency head. A pop on a non-empty
//               buffer frees its slot before a same-cycle push is judged, so
//               push and pop together are accepted even when full. A push
//               that finds no room is ignored (caller flags overflow).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               push,
  input  ps2_event_t         push_data,
  input  logic               pop,
  output logic               full,
  output logic               empty,
  output logic [c_CNT_W-1:0] count,
  output ps2_event_t         head
);

  // A depth of one still gets a one-bit pointer that simply never moves
  localparam int                 c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                 c_SLOTS = 1 << c_PTR_W;
  localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(DEPTH - 1);
  localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

  ps2_event_t         r_mem [c_SLOTS];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_pop;
  logic               w_push;

  assign full   = (r_count == c_FULL);
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign head   = r_mem[r_rd_ptr];
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);

  function automatic logic [c_PTR_W-1:0] ptr_next(input logic [c_PTR_W-1:0] ptr);
    return (ptr == c_LAST) ? '0 : ptr + 1'b1;
  endfunction

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // Storage array; contents are only meaningful while counted
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/ps2_scancode_decoder.sv
// ============================================================================
// Module      : ps2_scancode_decoder
// Description : Folds PS/2 set-2 prefix bytes (E0 extended, F0 release) into
//               key events, buffers them and exposes status/event words on a
//               simple read bus. Parity-corrupt bytes abort any prefix.
//               Build option PS2_EVENT_FIFO_EN: FIFO of FIFO_DEPTH events;
//               when undefined a single holding register is used instead.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  scancode,
  input  logic        scancode_valid,
  input  logic        parity_error,
  input  logic        read,
  input  logic        status_cs,
  input  logic        event_cs,
  output logic [31:0] data_out,
  output logic        data_out_valid,
  output logic        event_ready
);

`ifdef PS2_EVENT_FIFO_EN
  localparam int c_BUF_DEPTH = FIFO_DEPTH;
`else
  localparam int c_BUF_DEPTH = (FIFO_DEPTH > 0) ? 1 : 1;
`endif

  ps2_state_t         r_state;
  ps2_state_t         w_state_next;
  logic               w_push;
  ps2_event_t         w_push_event;
  logic               r_overflow;
  logic               r_parity;
  logic               w_full;
  logic               w_empty;
  logic [c_CNT_W-1:0] w_count;
  ps2_event_t         w_head;
  logic               w_status_rd;
  logic               w_event_rd;
  logic               w_ovf_set;
  logic               w_par_set;
  logic [c_STS_CNT_W-1:0] w_cnt_rpt;
  logic [31:0]        w_status_word;
  logic [31:0]        w_event_word;

  // Status takes priority, so a dual-select read never consumes an event
  assign w_status_rd = read & status_cs;
  assign w_event_rd  = read & event_cs & ~status_cs;
  assign w_par_set   = scancode_valid & parity_error;
  // A pop on a non-empty buffer frees the slot, so only an unpaired push drops
  assign w_ovf_set   = w_push & w_full & ~(w_event_rd & ~w_empty);

  // Prefix state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // Prefix decoding and event generation
  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    w_push_event = '{code: scancode, released: 1'b0, extended: 1'b0};
    if (scancode_valid) begin
      if (parity_error) begin
        w_state_next = ST_IDLE;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (scancode == c_PREFIX_EXT)      w_state_next = ST_GOT_E0;
            else if (scancode == c_PREFIX_BRK) w_state_next = ST_GOT_F0;
            else                               w_push = 1'b1;
          end
          ST_GOT_E0: begin
            if (scancode == c_PREFIX_BRK)      w_state_next = ST_GOT_E0F0;
            else if (scancode != c_PREFIX_EXT) begin
              w_push                = 1'b1;
              w_push_event.extended = 1'b1;
              w_state_next          = ST_IDLE;
            end
          end
          ST_GOT_F0: begin
            w_push                = 1'b1;
            w_push_event.released = 1'b1;
            w_state_next          = ST_IDLE;
          end
          ST_GOT_E0F0: begin
            w_push                = 1'b1;
            w_push_event.released = 1'b1;
            w_push_event.extended = 1'b1;
            w_state_next          = ST_IDLE;
          end
          default: w_state_next = ST_IDLE;
        endcase
      end
    end
  end

  ps2_event_fifo #(
    .DEPTH     (c_BUF_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (w_push),
    .push_data (w_push_event),
    .pop       (w_event_rd),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count),
    .head      (w_head)
  );

  // Sticky error flags; a same-cycle set overrides the status-read clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
      r_parity   <= 1'b0;
    end else begin
      r_overflow <= w_ovf_set | (r_overflow & ~w_status_rd);
      r_parity   <= w_par_set | (r_parity & ~w_status_rd);
    end
  end

  assign event_ready = ~w_empty;
  assign w_cnt_rpt   = (w_count > c_CNT_W'(31)) ? 5'd31 : w_count[c_STS_CNT_W-1:0];

  // Bus word assembly and read mux
  always_comb begin
    w_status_word                                  = 32'h0;
    w_status_word[c_STS_READY_BIT]                 = ~w_empty;
    w_status_word[c_STS_OVF_BIT]                   = r_overflow;
    w_status_word[c_STS_PAR_BIT]                   = r_parity;
    w_status_word[c_STS_CNT_LSB +: c_STS_CNT_W]    = w_cnt_rpt;
    w_event_word = w_empty ? 32'h0 : event_word(w_head);
    if (status_cs)     data_out = w_status_word;
    else if (event_cs) data_out = w_event_word;
    else               data_out = 32'h0;
    data_out_valid = read & (status_cs | event_cs);
  end

endmodule

`default_nettype wire

// File: tb/tb_ps2_scancode_decoder.sv
// ============================================================================
// Module      : tb_ps2_scancode_decoder
// Description : Self-checking bench for ps2_scancode_decoder. A queue-based
//               reference model tracks pending prefixes as two flags and the
//               buffered events as a queue; every cycle the bus outputs are
//               compared with it. Directed sequences pin known words, then a
//               randomized run exercises prefixes, parity, overflow, reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_scancode_decoder;

`ifdef PS2_EVENT_FIFO_EN
  localparam int MDEPTH = 8;
`else
  localparam int MDEPTH = 1;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  scancode = 8'h00;
  logic        scancode_valid = 1'b0;
  logic        parity_error = 1'b0;
  logic        read = 1'b0;
  logic        status_cs = 1'b0;
  logic        event_cs = 1'b0;
  logic [31:0] data_out;
  logic        data_out_valid;
  logic        event_ready;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [9:0] mq[$];
  logic m_ext, m_rel, m_ovf, m_par;

  ps2_scancode_decoder #(
    .FIFO_DEPTH     (8)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .scancode       (scancode),
    .scancode_valid (scancode_valid),
    .parity_error   (parity_error),
    .read           (read),
    .status_cs      (status_cs),
    .event_cs       (event_cs),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .event_ready    (event_ready)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    mq.delete();
    m_ext = 1'b0; m_rel = 1'b0; m_ovf = 1'b0; m_par = 1'b0;
  endtask

  function automatic logic [31:0] model_data_out();
    logic [31:0] w;
    int n;
    n = mq.size();
    if (status_cs) begin
      w = {(n > 0), m_ovf, m_par, ((n > 31) ? 5'd31 : 5'(n)), 24'h0};
    end else if (event_cs && n > 0) begin
      w = {mq[0], 22'h0};
    end else begin
      w = 32'h0;
    end
    return w;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_update();
    logic do_push, ovf_set, par_set;
    logic [9:0] ent;
    do_push = 1'b0; ovf_set = 1'b0; par_set = 1'b0; ent = '0;
    if (scancode_valid) begin
      if (parity_error) begin
        m_ext = 1'b0; m_rel = 1'b0; par_set = 1'b1;
      end else if (m_rel) begin
        ent = {scancode, 1'b1, m_ext}; do_push = 1'b1;
        m_ext = 1'b0; m_rel = 1'b0;
      end else if (scancode == 8'hE0) begin
        m_ext = 1'b1;
      end else if (scancode == 8'hF0) begin
        m_rel = 1'b1;
      end else begin
        ent = {scancode, 1'b0, m_ext}; do_push = 1'b1;
        m_ext = 1'b0;
      end
    end
    if (read && event_cs && !status_cs && mq.size() > 0) void'(mq.pop_front());
    if (do_push) begin
      if (mq.size() < MDEPTH) mq.push_back(ent);
      else                    ovf_set = 1'b1;
    end
    if (read && status_cs) begin
      m_ovf = 1'b0; m_par = 1'b0;
    end
    if (ovf_set) m_ovf = 1'b1;
    if (par_set) m_par = 1'b1;
  endtask

  task automatic compare(input string nm, input logic lit_en, input logic [31:0] lit);
    logic [31:0] exp_do;
    logic        exp_v, exp_r;
    exp_do = model_data_out();
    exp_v  = read & (status_cs | event_cs);
    exp_r  = (mq.size() > 0);
    vectors++;
    if (data_out !== exp_do) begin
      miscompares++;
      $display("FAIL %s data_out: got %08h expected %08h", nm, data_out, exp_do);
    end
    vectors++;
    if (data_out_valid !== exp_v) begin
      miscompares++;
      $display("FAIL %s data_out_valid: got %b expected %b", nm, data_out_valid, exp_v);
    end
    vectors++;
    if (event_ready !== exp_r) begin
      miscompares++;
      $display("FAIL %s event_ready: got %b expected %b", nm, event_ready, exp_r);
    end
    if (lit_en) begin
      vectors++;
      if (data_out !== lit) begin
        miscompares++;
        $display("FAIL %s literal: got %08h expected %08h", nm, data_out, lit);
      end
    end
  endtask

  // One clock of stimulus: drive on the falling edge, check, then model the edge
  task automatic step(input logic rst, input logic sv, input logic [7:0] sc,
                      input logic pe, input logic rd, input logic scs, input logic ecs,
                      input logic lit_en, input logic [31:0] lit, input string nm);
    @(negedge clock);
    reset_n        = ~rst;
    scancode_valid = sv;
    scancode       = sc;
    parity_error   = pe;
    read           = rd;
    status_cs      = scs;
    event_cs       = ecs;
    if (rst) model_reset();
    #1;
    compare(nm, lit_en, lit);
    if (!rst) model_update();
  endtask

  task automatic send(input logic [7:0] sc);
    step(1'b0, 1'b1, sc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "send");
  endtask

  task automatic rd_evt(input logic [31:0] lit, input string nm);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, lit, nm);
  endtask

  task automatic rd_sts(input logic [31:0] lit, input string nm);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, lit, nm);
  endtask

  initial begin
    model_reset();
    // Reset state
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, "reset_status");
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, "idle_zero");

    // Plain make code
    send(8'h1C);
    rd_evt(32'h1C00_0000, "make_1C");
    rd_sts(32'h0000_0000, "drained");

    // Extended release and plain release
    send(8'hE0); send(8'hF0); send(8'h75);
    rd_evt(32'h75C0_0000, "ext_break_75");
    send(8'hF0); send(8'h1C);
    rd_evt(32'h1C80_0000, "break_1C");

    // Reset discards a pending prefix
    send(8'hE0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "mid_reset");
    send(8'h1C);
    rd_evt(32'h1C00_0000, "after_reset_1C");

    // Empty event read returns zero and changes nothing
    rd_evt(32'h0, "empty_read");

    // Overflow: nine make codes
    for (int i = 1; i <= 9; i++) send(8'(i));
`ifdef PS2_EVENT_FIFO_EN
    rd_sts(32'hC800_0000, "overflow_status");
`else
    rd_sts(32'hC100_0000, "overflow_status");
`endif
    for (int i = 1; i <= MDEPTH; i++) rd_evt({8'(i), 24'h0}, "overflow_order");
    rd_sts(32'h0000_0000, "overflow_cleared");

    // Parity error aborts the E0 prefix; following F0 starts from idle
    send(8'hE0);
    step(1'b0, 1'b1, 8'h1C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "parity_byte");
    rd_sts(32'h2000_0000, "parity_status");
    send(8'hF0); send(8'h1C);
    rd_evt(32'h1C80_0000, "post_parity_break");

    // Status wins when both selects are high
    send(8'h2A);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h8100_0000, "dual_select");
    rd_evt(32'h2A00_0000, "dual_select_evt");

    // Full buffer: push and pop in the same cycle
    for (int i = 0; i < MDEPTH; i++) send(8'(8'h10 + i));
    step(1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1000_0000, "full_push_pop");
`ifdef PS2_EVENT_FIFO_EN
    rd_sts(32'h8800_0000, "full_push_pop_status");
`else
    rd_sts(32'h8100_0000, "full_push_pop_status");
`endif
    for (int i = 1; i < MDEPTH; i++) rd_evt({8'(8'h10 + i), 24'h0}, "full_drain");
    rd_evt(32'h5500_0000, "full_new_last");

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic       r_rst, r_sv, r_pe, r_rd, r_scs, r_ecs;
      logic [7:0] r_sc;
      int         pick;
      r_rst = ($urandom_range(0, 199) == 0);
      r_sv  = ($urandom_range(0, 1) == 1);
      pick  = int'($urandom_range(0, 9));
      if (pick < 2)       r_sc = 8'hE0;
      else if (pick == 2) r_sc = 8'hF0;
      else                r_sc = 8'($urandom);
      r_pe  = ($urandom_range(0, 19) == 0);
      r_rd  = ($urandom_range(0, 9) < 4);
      pick  = int'($urandom_range(0, 3));
      if (r_rd) begin
        r_scs = (pick == 0);
        r_ecs = (pick != 0);
      end else begin
        r_scs = pick[0];
        r_ecs = pick[1];
      end
      step(r_rst, r_sv, r_sc, r_pe, r_rd, r_scs, r_ecs, 1'b0, 32'h0, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
